day10_crt_sequencer: RTL and testbench

- Drives the combinational program ROM one entry per emulated CPU cycle and accumulates the signed X register.
- Generates one CRT pixel per cycle (sprite test), with a valid/ready handshake toward the framebuffer/display writer.
- Optionally accumulates the signal-strength sum for the status/readout logic.
- Sits between the program ROM and the framebuffer writer.

---
 rtl/day10_crt_sequencer_if.sv | 19 +
 rtl/day10_crt_sequencer.sv | 152 +++++++++++++++
 tb/tb_day10_crt_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/day10_crt_sequencer_if.sv
// Pixel stream bundle between the CRT sequencer and the framebuffer writer.
// master drives pix_valid/pix_x/pix_y/pix_on; slave drives pix_ready.
interface day10_crt_sequencer_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_on;

    modport master (
        output pix_valid, pix_x, pix_y, pix_on,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_on,
        output pix_ready
    );
endinterface

// File: rtl/day10_crt_sequencer.sv
// CRT sequencer: steps the program ROM once per accepted pixel, keeps the
// signed X register and emits one sprite-test pixel per emulated CPU cycle.
// Ports: clk, rst (async, active-high), start pulse, rom_addr/rom_data,
// screen_w/screen_h, pix (pixel handshake, master), x_reg, busy, done,
// signal_sum. Optional macro DAY10_SIGNAL_SUM_EN enables the signal-strength
// accumulator; without it signal_sum is tied to zero.
module day10_crt_sequencer #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PROG_LEN   = 240,
    parameter int X_WIDTH    = 16,
    parameter int SUM_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [ADDR_BITS-1:0]        rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_data,
    input  logic [7:0]                  screen_w,
    input  logic [7:0]                  screen_h,
    day10_crt_sequencer_if.master       pix,
    output logic signed [X_WIDTH-1:0]   x_reg,
    output logic                        busy,
    output logic                        done,
    output logic [SUM_WIDTH-1:0]        signal_sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CYC_BITS = ADDR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PROG_LEN - 1);

    state_t state;
    state_t state_nxt;

    logic [CYC_BITS-1:0] cyc;
    logic [7:0]          pix_x_q;
    logic [7:0]          pix_y_q;
    logic                accept;
    logic                launch;
    logic                last;
    logic signed [X_WIDTH:0] diff;

    assign accept = (state == S_RUN) && pix.pix_ready;
    assign launch = start && (state != S_RUN);
    assign last   = (rom_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        pix.pix_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy          = 1'b1;
                pix.pix_valid = 1'b1;
                if (accept && last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            x_reg    <= X_WIDTH'(1);
            cyc      <= CYC_BITS'(1);
        end else if (launch) begin
            rom_addr <= '0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            x_reg    <= X_WIDTH'(1);
            cyc      <= CYC_BITS'(1);
        end else if (accept) begin
            x_reg <= x_reg + X_WIDTH'($signed(rom_data));
            // The final entry leaves position counters on the last pixel.
            if (!last) begin
                rom_addr <= rom_addr + ADDR_BITS'(1);
                cyc      <= cyc + CYC_BITS'(1);
                if (pix_x_q == screen_w - 8'd1) begin
                    pix_x_q <= '0;
                    pix_y_q <= pix_y_q + 8'd1;
                end else begin
                    pix_x_q <= pix_x_q + 8'd1;
                end
            end
        end
    end

    // One extra bit keeps a negative or large X from wrapping into a match.
    assign diff = $signed({{(X_WIDTH - 7){1'b0}}, pix_x_q})
                - $signed({x_reg[X_WIDTH-1], x_reg});

    assign pix.pix_x  = pix_x_q;
    assign pix.pix_y  = pix_y_q;
    assign pix.pix_on = busy && ((diff == '1) ||
                                 (diff == '0) ||
                                 (diff == (X_WIDTH + 1)'(1)));

`ifdef DAY10_SIGNAL_SUM_EN
    logic                 hit;
    logic [SUM_WIDTH-1:0] prod;

    assign hit = (cyc == CYC_BITS'(20))  || (cyc == CYC_BITS'(60))  ||
                 (cyc == CYC_BITS'(100)) || (cyc == CYC_BITS'(140)) ||
                 (cyc == CYC_BITS'(180)) || (cyc == CYC_BITS'(220));

    // Low SUM_WIDTH bits of the product are correct for a negative X.
    assign prod = SUM_WIDTH'(x_reg) * SUM_WIDTH'(cyc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signal_sum <= '0;
        end else if (launch) begin
            signal_sum <= '0;
        end else if (accept && hit) begin
            signal_sum <= signal_sum + prod;
        end
    end
`else
    logic unused_cyc;

    assign unused_cyc = ^cyc;
    assign signal_sum = '0;
`endif

    logic unused_screen_h;

    assign unused_screen_h = ^screen_h;

endmodule

// File: tb/tb_day10_crt_sequencer.sv
// Directed bench for day10_crt_sequencer with a pixel scoreboard.
// A 240-entry and a 5-entry instance share the ROM array and handshake.
module tb_day10_crt_sequencer;

`ifdef DAY10_SIGNAL_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    typedef struct {
        int                 x;
        int                 y;
        bit                 on;
        logic signed [15:0] xpre;
        logic signed [15:0] xpost;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic sel = 1'b0;
    logic [7:0] screen_w = 8'd40;
    logic [7:0] screen_h = 8'd6;
    logic [7:0] rom [256];

    logic [7:0]         addr_a, addr_b, data_a, data_b;
    logic signed [15:0] xr_a, xr_b;
    logic               busy_a, busy_b, done_a, done_b;
    logic [31:0]        sum_a, sum_b;

    logic               c_valid, c_on, c_busy, c_done;
    logic [7:0]         c_x, c_y, c_addr;
    logic signed [15:0] c_xr;
    logic [31:0]        c_sum;

    pix_t q[$];
    int   exp_sum;
    logic signed [15:0] exp_x;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   acc_cnt;
    int   lit_cnt;
    bit   row0_on [256];

    day10_crt_sequencer_if pix_a ();
    day10_crt_sequencer_if pix_b ();

    assign pix_a.pix_ready = ready;
    assign pix_b.pix_ready = ready;
    assign data_a = rom[addr_a];
    assign data_b = rom[addr_b];

    day10_crt_sequencer #(.PROG_LEN(240)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start & ~sel),
        .rom_addr   (addr_a),
        .rom_data   (data_a),
        .screen_w   (screen_w),
        .screen_h   (screen_h),
        .pix        (pix_a.master),
        .x_reg      (xr_a),
        .busy       (busy_a),
        .done       (done_a),
        .signal_sum (sum_a)
    );

    day10_crt_sequencer #(.PROG_LEN(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .start      (start & sel),
        .rom_addr   (addr_b),
        .rom_data   (data_b),
        .screen_w   (screen_w),
        .screen_h   (screen_h),
        .pix        (pix_b.master),
        .x_reg      (xr_b),
        .busy       (busy_b),
        .done       (done_b),
        .signal_sum (sum_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        c_valid = sel ? pix_b.pix_valid : pix_a.pix_valid;
        c_on    = sel ? pix_b.pix_on    : pix_a.pix_on;
        c_x     = sel ? pix_b.pix_x     : pix_a.pix_x;
        c_y     = sel ? pix_b.pix_y     : pix_a.pix_y;
        c_addr  = sel ? addr_b : addr_a;
        c_xr    = sel ? xr_b   : xr_a;
        c_busy  = sel ? busy_b : busy_a;
        c_done  = sel ? done_b : done_a;
        c_sum   = sel ? sum_b  : sum_a;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else begin
            fails++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model: expected pixel and X for every cycle of a run.
    task automatic build(input int plen);
        logic signed [15:0] x;
        int d;
        pix_t p;
        x = 16'sd1;
        exp_sum = 0;
        q.delete();
        for (int n = 0; n < plen; n++) begin
            p.x  = n % int'(screen_w);
            p.y  = n / int'(screen_w);
            d    = p.x - int'(x);
            p.on = (d >= -1) && (d <= 1);
            p.xpre = x;
            if ((n + 1) inside {20, 60, 100, 140, 180, 220})
                exp_sum += (n + 1) * int'(x);
            x = x + {{8{rom[n][7]}}, rom[n]};
            p.xpost = x;
            q.push_back(p);
        end
        exp_x = x;
    endtask

    task automatic run(input int plen, input bit bp,
                       input int start_at, input int rst_at);
        pix_t p;
        bit acc;
        int budget;
        build(plen);
        acc_cnt = 0;
        lit_cnt = 0;
        budget = 0;
        for (int i = 0; i < 256; i++) row0_on[i] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (acc_cnt < plen && budget < 4000) begin
            ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            start = (acc_cnt == start_at);
            #1;
            acc = c_valid && ready;
            if (c_valid) begin
                p = q[0];
                chk("pix_x", 32'(c_x), p.x);
                chk("pix_y", 32'(c_y), p.y);
                chk("pix_on", 32'(c_on), 32'(p.on));
                chk("x_pre", c_xr, p.xpre);
                chk("rom_addr", 32'(c_addr), acc_cnt);
                if (acc && c_y == 8'd0) row0_on[c_x] = c_on;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc) begin
                void'(q.pop_front());
                acc_cnt++;
                if (p.on) lit_cnt++;
                chk("x_post", c_xr, p.xpost);
                if (acc_cnt == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_busy", 32'(c_busy), 0);
                    chk("rst_valid", 32'(c_valid), 0);
                    chk("rst_x", c_xr, 1);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
            budget++;
            @(negedge clk);
        end
        chk("accept_budget", acc_cnt, plen);
        @(negedge clk);
        chk("end_done", 32'(c_done), 1);
        chk("end_busy", 32'(c_busy), 0);
        chk("end_valid", 32'(c_valid), 0);
        chk("end_x", c_xr, exp_x);
        chk("end_addr", 32'(c_addr), plen - 1);
        chk("end_pix_x", 32'(c_x), p.x);
        chk("end_pix_y", 32'(c_y), p.y);
        chk("end_sum", c_sum, SUM_ON ? exp_sum : 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_state_busy", 32'(busy_a), 0);
        chk("rst_state_done", 32'(done_a), 0);
        chk("rst_state_valid", 32'(pix_a.pix_valid), 0);
        chk("rst_state_x", xr_a, 1);
        chk("rst_state_addr", 32'(addr_a), 0);
        chk("rst_state_sum", sum_a, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy_a), 0);

        // All-zero program
        run(240, 1'b0, -1, -1);
        chk("t1_accepts", acc_cnt, 240);
        chk("t1_lit", lit_cnt, 18);
        chk("t1_x", c_xr, 1);
        chk("t1_rows", 32'(c_y), 5);
        chk("t1_sum", c_sum, SUM_ON ? 720 : 0);

        // Short program on the 5-entry instance
        sel = 1'b1;
        rom[2] = 8'd3;
        rom[4] = 8'hFB;
        run(5, 1'b0, -1, -1);
        chk("t2_lit", lit_cnt, 5);
        chk("t2_x", c_xr, 32'hFFFF_FFFF);
        chk("t2_addr", 32'(c_addr), 4);
        sel = 1'b0;
        rom[2] = 8'd0;
        rom[4] = 8'd0;

        // X = 5 from cycle 2
        rom[0] = 8'd4;
        run(240, 1'b0, -1, -1);
        chk("t3_x", c_xr, 5);
        chk("t3_sum", c_sum, SUM_ON ? 3600 : 0);

        // Same program under random back-pressure
        run(240, 1'b1, -1, -1);
        chk("t4_accepts", acc_cnt, 240);
        chk("t4_x", c_xr, 5);
        chk("t4_sum", c_sum, SUM_ON ? 3600 : 0);

        // Start during RUN, then reset at accept 100, then a full rerun
        run(240, 1'b0, 50, 100);
        chk("t5_idle_done", 32'(done_a), 0);
        run(240, 1'b0, -1, -1);
        chk("t5_x", c_xr, 5);

        // Negative X must not alias at the row edges
        rom[0] = 8'hFD;
        run(240, 1'b0, -1, -1);
        chk("t6_col1", 32'(row0_on[1]), 0);
        chk("t6_col39", 32'(row0_on[39]), 0);
        chk("t6_x", c_xr, 32'hFFFF_FFFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
